debounce_pulser: RTL and testbench



---
 rtl/debounce_pulser_if.sv | 28 ++
 rtl/debounce_pulser.sv | 189 ++++++++++++++++++
 tb/tb_debounce_pulser.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debounce_pulser_if.sv
// debounce_pulser_if: button-side and event-side signals of the debounce
// front end. The master drives the raw button levels and consumes the
// debounced events; the slave (the debouncer) does the opposite.
interface debounce_pulser_if #(
    parameter int N = 5
);
    logic [N-1:0] in;         // raw, asynchronous, active-high button levels
    logic [N-1:0] pulse;      // one-cycle press / repeat pulse
    logic [N-1:0] rel_pulse;  // one-cycle release pulse
    logic [N-1:0] level;      // debounced level
    logic [N-1:0] held;       // channel is in its auto-repeat phase

    modport master (
        output in,
        input  pulse,
        input  rel_pulse,
        input  level,
        input  held
    );

    modport slave (
        input  in,
        output pulse,
        output rel_pulse,
        output level,
        output held
    );
endinterface

// File: rtl/debounce_pulser.sv
// debounce_pulser: N independent push-button channels. Each channel
// synchronises its raw input, debounces it with a stability counter and emits
// registered one-cycle press and release pulses plus the debounced level.
// Optional auto-repeat (define DEBOUNCE_PULSER_REPEAT_EN) adds a per-channel
// IDLE/DELAY/REPEAT FSM that re-fires the press pulse while a button is held.
// Without the macro no FSM or repeat counter exists and held is tied low.
module debounce_pulser #(
    parameter int N             = 5,
    parameter int DB_CYCLES     = 1_000_000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    debounce_pulser_if.slave  bus
);

    // Debounce counter: wide enough to hold DB_CYCLES-1, never narrower than 1.
    localparam int               CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0]    DB_LAST = CW'(DB_CYCLES - 1);

    // Repeat counter: shared width for both the initial delay and the period.
    localparam int               R_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int               RCW     = (R_MAX > 1) ? $clog2(R_MAX) : 1;
    localparam logic [RCW-1:0]   RD_LAST = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0]   RP_LAST = RCW'(REPEAT_PERIOD - 1);

`ifdef DEBOUNCE_PULSER_REPEAT_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_e;
`else
    // Repeat timing is accepted but has no hardware in this build.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{RD_LAST, RP_LAST};
`endif

    logic [N-1:0] pulse_vec;
    logic [N-1:0] rel_vec;
    logic [N-1:0] level_vec;
    logic [N-1:0] held_vec;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            logic          sync1_reg;
            logic          in_s_reg;
            logic [CW-1:0] cnt_reg;
            logic          level_reg;
            logic          pulse_reg;
            logic          rel_reg;

            logic          commit;
            logic          press_commit;
            logic          rel_commit;
            logic          rep_fire;
            logic          held_w;

            // A commit happens when the synchronised input has disagreed with
            // the debounced level for DB_CYCLES consecutive cycles.
            assign commit       = (in_s_reg != level_reg) && (cnt_reg == DB_LAST);
            assign press_commit = commit &  in_s_reg;
            assign rel_commit   = commit & ~in_s_reg;

            // Two-flop synchroniser for the asynchronous button level.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b0;
                    in_s_reg  <= 1'b0;
                end else begin
                    sync1_reg <= bus.in[gi];
                    in_s_reg  <= sync1_reg;
                end
            end

            // Stability counter and debounced level; any return to the old
            // level restarts the count.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                end else if (in_s_reg == level_reg) begin
                    cnt_reg   <= '0;
                end else if (cnt_reg == DB_LAST) begin
                    cnt_reg   <= '0;
                    level_reg <= in_s_reg;
                end else begin
                    cnt_reg   <= cnt_reg + CW'(1);
                end
            end

            // Registered event pulses: press (or repeat) and release.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pulse_reg <= 1'b0;
                    rel_reg   <= 1'b0;
                end else begin
                    pulse_reg <= press_commit | rep_fire;
                    rel_reg   <= rel_commit;
                end
            end

`ifdef DEBOUNCE_PULSER_REPEAT_EN
            rep_state_e     state_reg;
            rep_state_e     state_next;
            logic [RCW-1:0] rcnt_reg;
            logic [RCW-1:0] rcnt_next;

            // Repeat FSM state and cycle counter registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= ST_IDLE;
                    rcnt_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    rcnt_reg  <= rcnt_next;
                end
            end

            // Next-state logic: a release commit always wins and returns to IDLE.
            always_comb begin
                state_next = state_reg;
                rcnt_next  = rcnt_reg;
                if (rel_commit) begin
                    state_next = ST_IDLE;
                    rcnt_next  = '0;
                end else begin
                    case (state_reg)
                        ST_IDLE: begin
                            if (press_commit) begin
                                state_next = ST_DELAY;
                                rcnt_next  = '0;
                            end
                        end
                        ST_DELAY: begin
                            if (rcnt_reg == RD_LAST) begin
                                state_next = ST_REPEAT;
                                rcnt_next  = '0;
                            end else begin
                                rcnt_next  = rcnt_reg + RCW'(1);
                            end
                        end
                        ST_REPEAT: begin
                            if (rcnt_reg == RP_LAST) begin
                                rcnt_next  = '0;
                            end else begin
                                rcnt_next  = rcnt_reg + RCW'(1);
                            end
                        end
                        default: begin
                            state_next = ST_IDLE;
                            rcnt_next  = '0;
                        end
                    endcase
                end
            end

            // Output decode: a repeat due on the release edge is suppressed.
            always_comb begin
                rep_fire = 1'b0;
                held_w   = (state_reg == ST_REPEAT);
                if (!rel_commit) begin
                    if (state_reg == ST_DELAY && rcnt_reg == RD_LAST) begin
                        rep_fire = 1'b1;
                    end
                    if (state_reg == ST_REPEAT && rcnt_reg == RP_LAST) begin
                        rep_fire = 1'b1;
                    end
                end
            end
`else
            assign rep_fire = 1'b0;
            assign held_w   = 1'b0;
`endif

            assign pulse_vec[gi] = pulse_reg;
            assign rel_vec[gi]   = rel_reg;
            assign level_vec[gi] = level_reg;
            assign held_vec[gi]  = held_w;
        end
    endgenerate

    assign bus.pulse     = pulse_vec;
    assign bus.rel_pulse = rel_vec;
    assign bus.level     = level_vec;
    assign bus.held      = held_vec;

endmodule

// File: tb/tb_debounce_pulser.sv
// tb_debounce_pulser: scoreboard bench for debounce_pulser with N=2,
// DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8. A reference model computes
// the expected outputs for every clock edge from run lengths of the sampled
// input and pushes them into a queue; a monitor pops and compares each cycle.
// Directed scenarios add absolute timing/count checks; a random phase follows.
module tb_debounce_pulser;

    localparam int N  = 2;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;
`ifdef DEBOUNCE_PULSER_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] in_drv = '0;

    always #5 clk = ~clk;

    debounce_pulser_if #(.N(N)) bus ();
    assign bus.in = in_drv;

    debounce_pulser #(
        .N(N), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct packed {
        logic [N-1:0] pulse;
        logic [N-1:0] rel;
        logic [N-1:0] level;
        logic [N-1:0] held;
        logic [31:0]  edge_no;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int n_repeats(input int hold);
        int c;
        c = 0;
        if (REP_ON) begin
            for (int k = 0; RD + RP * k < hold; k++) c++;
        end
        return c;
    endfunction

    // ---------------- reference model ----------------
    // Level changes once the delayed (two-edge) sample stream has shown the
    // new value for DB consecutive edges; repeats follow press time arithmetic.
    int   edge_n = 0;
    logic [N-1:0] d1 = '0, d2 = '0;
    bit   cur_v [N];
    bit   lvl_m [N];
    int   since [N];
    int   pstart[N];

    always @(posedge clk) begin
        exp_t e;
        edge_n++;
        e = '0;
        e.edge_no = edge_n;
        if (!rst_n) begin
            d1 = '0;
            d2 = '0;
            for (int i = 0; i < N; i++) begin
                cur_v[i] = 1'b0; lvl_m[i] = 1'b0; since[i] = edge_n; pstart[i] = edge_n;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                bit press, rel, rep;
                press = 0; rel = 0; rep = 0;
                if (d2[i] != cur_v[i]) begin
                    cur_v[i] = d2[i];
                    since[i] = edge_n;
                end
                if (cur_v[i] != lvl_m[i] && edge_n - since[i] == DB - 1) begin
                    lvl_m[i] = cur_v[i];
                    if (cur_v[i]) begin press = 1; pstart[i] = edge_n; end
                    else rel = 1;
                end
                if (REP_ON && lvl_m[i] && !press) begin
                    int k;
                    k = edge_n - pstart[i];
                    if (k >= RD && (k - RD) % RP == 0) rep = 1;
                end
                e.pulse[i] = press | rep;
                e.rel[i]   = rel;
                e.level[i] = lvl_m[i];
                e.held[i]  = REP_ON && lvl_m[i] && (edge_n - pstart[i] >= RD);
            end
            d2 = d1;
            d1 = in_drv;
        end
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    int pulse_cnt[N], rel_cnt[N], held_cnt[N];
    int first_pulse[N], last_pulse[N], first_rel[N], first_held[N];
    int both_cnt;

    task automatic clear_stats();
        for (int i = 0; i < N; i++) begin
            pulse_cnt[i] = 0; rel_cnt[i] = 0; held_cnt[i] = 0;
            first_pulse[i] = -1; last_pulse[i] = -1; first_rel[i] = -1; first_held[i] = -1;
        end
        both_cnt = 0;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("pulse",     int'(bus.pulse),     int'(e.pulse));
            check("rel_pulse", int'(bus.rel_pulse), int'(e.rel));
            check("level",     int'(bus.level),     int'(e.level));
            check("held",      int'(bus.held),      int'(e.held));
            check("pulse_and_rel_exclusive", int'(bus.pulse & bus.rel_pulse), 0);
        end
        for (int i = 0; i < N; i++) begin
            if (bus.pulse[i]) begin
                pulse_cnt[i]++;
                if (first_pulse[i] < 0) first_pulse[i] = edge_n;
                last_pulse[i] = edge_n;
            end
            if (bus.rel_pulse[i]) begin
                rel_cnt[i]++;
                if (first_rel[i] < 0) first_rel[i] = edge_n;
            end
            if (bus.held[i]) begin
                held_cnt[i]++;
                if (first_held[i] < 0) first_held[i] = edge_n;
            end
        end
        if (bus.pulse == {N{1'b1}}) both_cnt++;
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold in_drv[ch] high for 'hold' samples starting at the returned edge.
    task automatic press_hold(input logic [N-1:0] mask, input int hold, output int e0);
        @(negedge clk);
        in_drv = in_drv | mask;
        e0 = edge_n + 1;
        cycles(hold);
        in_drv = in_drv & ~mask;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e0, b0, r0;
        int run_left[N];
        clear_stats();

        // Reset state
        rst_n  = 1'b0;
        in_drv = '0;
        cycles(3);
        check("reset_pulse", int'(bus.pulse), 0);
        check("reset_level", int'(bus.level), 0);
        check("reset_held",  int'(bus.held),  0);
        rst_n = 1'b1;
        cycles(4);

        // Clean press on channel 0, 50 cycles
        clear_stats();
        press_hold(2'b01, 50, e0);
        cycles(12);
        $display("clean press: e0=%0d pulses=%0d first=%0d rel=%0d", e0, pulse_cnt[0], first_pulse[0], first_rel[0]);
        check("clean_pulse_count", pulse_cnt[0], 1 + n_repeats(50));
        check("clean_pulse_edge",  first_pulse[0], e0 + DB + 1);
        check("clean_rel_count",   rel_cnt[0], 1);
        check("clean_rel_edge",    first_rel[0], e0 + 50 + DB + 1);
        check("clean_ch1_pulse",   pulse_cnt[1], 0);
        check("clean_ch1_rel",     rel_cnt[1], 0);

        // Glitch: 3 cycles high
        clear_stats();
        press_hold(2'b01, 3, e0);
        cycles(12);
        $display("glitch: e0=%0d pulses=%0d rel=%0d", e0, pulse_cnt[0], rel_cnt[0]);
        check("glitch_pulse_count", pulse_cnt[0], 0);
        check("glitch_rel_count",   rel_cnt[0], 0);
        check("glitch_level",       int'(bus.level[0]), 0);

        // Bounce: 1,0,1,0 every 2 cycles, then hold 1 from B
        clear_stats();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_drv[0] = (k % 2 == 0);
            @(negedge clk);
        end
        press_hold(2'b01, 15, b0);
        cycles(12);
        $display("bounce: b0=%0d pulses=%0d first=%0d", b0, pulse_cnt[0], first_pulse[0]);
        check("bounce_pulse_count", pulse_cnt[0], 1);
        check("bounce_pulse_edge",  first_pulse[0], b0 + DB + 1);

        // Long hold for auto-repeat (80 cycles)
        clear_stats();
        press_hold(2'b01, 80, e0);
        cycles(12);
        $display("long hold: e0=%0d pulses=%0d held_first=%0d last_pulse=%0d", e0, pulse_cnt[0], first_held[0], last_pulse[0]);
        check("hold_pulse_count", pulse_cnt[0], 1 + n_repeats(80));
        check("hold_held_first",  first_held[0], REP_ON ? e0 + DB + 1 + RD : -1);
        check("hold_rel_count",   rel_cnt[0], 1);
        check("hold_no_pulse_after_release", int'(last_pulse[0] < e0 + 80 + DB + 1), 1);
        check("hold_held_after_release", int'(bus.held[0]), 0);

        // Simultaneous press on both channels
        clear_stats();
        press_hold(2'b11, 10, e0);
        cycles(12);
        $display("simultaneous: e0=%0d first0=%0d first1=%0d both=%0d", e0, first_pulse[0], first_pulse[1], both_cnt);
        check("simul_both_same_cycle", both_cnt, 1);
        check("simul_edge_ch0", first_pulse[0], e0 + DB + 1);
        check("simul_edge_ch1", first_pulse[1], e0 + DB + 1);

        // Reset while channel 0 is debounced high and still pressed
        @(negedge clk);
        in_drv = 2'b01;
        cycles(12);
        check("pre_reset_level", int'(bus.level[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: pulse=%0b rel=%0b level=%0b held=%0b", bus.pulse, bus.rel_pulse, bus.level, bus.held);
        check("async_reset_level", int'(bus.level), 0);
        check("async_reset_pulse", int'(bus.pulse), 0);
        check("async_reset_rel",   int'(bus.rel_pulse), 0);
        check("async_reset_held",  int'(bus.held), 0);
        cycles(2);
        clear_stats();
        rst_n = 1'b1;
        r0 = edge_n + 1;
        cycles(20);
        in_drv = '0;
        cycles(12);
        $display("after reset: r0=%0d pulses=%0d first=%0d", r0, pulse_cnt[0], first_pulse[0]);
        check("post_reset_pulse_edge",  first_pulse[0], r0 + DB + 1);
        check("post_reset_pulse_count", pulse_cnt[0], 1);

        // Random phase: random run lengths per channel, with resets between blocks
        for (int i = 0; i < N; i++) run_left[i] = 0;
        for (int blk = 0; blk < 3; blk++) begin
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                for (int i = 0; i < N; i++) begin
                    if (run_left[i] == 0) begin
                        in_drv[i] = ~in_drv[i];
                        run_left[i] = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 6))
                                                                 : int'($urandom_range(5, 60));
                    end
                    run_left[i]--;
                end
            end
            $display("random block %0d done: compared=%0d mismatched=%0d", blk, n_cmp, n_bad);
            #2;
            rst_n = 1'b0;
            cycles(2);
            rst_n = 1'b1;
        end

        in_drv = '0;
        cycles(20);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
